uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 48 ++++
 rtl/uart_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Word-side bundle of the UART receiver: the received word, its valid/ready handshake and the error strobes.
// The receiver drives the master modport; the consumer uses the slave modport.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  frame_err;
    logic                  overrun;
`ifdef UART_RX_PARITY_EN
    logic                  parity_err;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        output parity_err,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        output ready
    );
`else
    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default; UART_RX_PARITY_EN adds an even parity bit and parity_err. ready only drains the output word; a word finishing while one is pending is dropped with an overrun pulse.
// valid rises exactly 2+HALF_PULSE_WIDTH+(DATA_WIDTH+1)*PULSE_WIDTH edges (+PULSE_WIDTH with parity) after the first clk edge that samples rx_sig low.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 200_000_000
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      rx_sig,
    uart_rx_if.master bus
);
    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CNT_W            = (PULSE_WIDTH > 2) ? $clog2(PULSE_WIDTH) : 1;
    localparam int BIT_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_rs;
    logic                  w_cnt_zero;

    logic [CNT_W-1:0]      r_clk_cnt;
    logic [CNT_W-1:0]      w_clk_cnt_nxt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [BIT_W-1:0]      w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shreg_nxt;

    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic                  r_frame_err;
    logic                  w_frame_err;
    logic                  r_overrun;
    logic                  w_overrun;
`ifdef UART_RX_PARITY_EN
    logic                  r_parity_err;
    logic                  w_parity_err;
`endif

    assign w_rs       = r_sync2;
    assign w_cnt_zero = (r_clk_cnt == '0);

    // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_sig;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rs) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    w_next_state = w_rs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_cnt_zero && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_zero) begin
                    w_next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Returning to IDLE at mid-stop arms detection of a back-to-back start bit.
                if (w_cnt_zero) begin
                    w_next_state = w_rs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_rs) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid && !bus.ready;
        w_frame_err   = 1'b0;
        w_overrun     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_err  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rs) begin
                    w_clk_cnt_nxt = HALF_RELOAD;
                end
            end
            S_START: begin
                if (!w_cnt_zero) begin
                    w_clk_cnt_nxt = r_clk_cnt - CNT_W'(1);
                end else if (!w_rs) begin
                    w_clk_cnt_nxt = FULL_RELOAD;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                if (!w_cnt_zero) begin
                    w_clk_cnt_nxt = r_clk_cnt - CNT_W'(1);
                end else begin
                    w_shreg_nxt[r_bit_cnt] = w_rs;
                    w_clk_cnt_nxt          = FULL_RELOAD;
                    if (r_bit_cnt != LAST_BIT) begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!w_cnt_zero) begin
                    w_clk_cnt_nxt = r_clk_cnt - CNT_W'(1);
                end else begin
                    w_parity_err  = (w_rs != ^r_shreg);
                    w_clk_cnt_nxt = FULL_RELOAD;
                end
            end
`endif
            S_STOP: begin
                if (!w_cnt_zero) begin
                    w_clk_cnt_nxt = r_clk_cnt - CNT_W'(1);
                end else if (w_rs) begin
                    // A pending word consumed this very cycle frees the register for the new one.
                    if (!r_valid || bus.ready) begin
                        w_data_nxt  = r_shreg;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_overrun = 1'b1;
                    end
                end else begin
                    w_frame_err = 1'b1;
                end
            end
            S_BREAK: begin
                w_clk_cnt_nxt = '0;
            end
            default: begin
                w_clk_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_clk_cnt    <= w_clk_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_frame_err  <= w_frame_err;
            r_overrun    <= w_overrun;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_parity_err;
`endif
        end
    end

    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at PULSE_WIDTH=10: directed frames, a per-cycle event model of the word side, and literal pins.
module tb_uart_rx;
    localparam int P = 10;
    localparam int H = 5;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int EV_WORD = 0;
    localparam int EV_FERR = 1;
    localparam int EV_PERR = 2;

    typedef struct {
        int         e;
        int         kind;
        logic [7:0] d;
    } ev_t;

    ev_t evq[$];

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_sig = 1'b1;
    logic       ready = 1'b1;

    int         edge_n = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_vrise = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         n_perr = 0;
    int         last_vrise = 0;

    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       ready_q = 1'b1;
    logic       rstn_q = 1'b0;
    logic       valid_q = 1'b0;

    uart_rx_if #(.DATA_WIDTH(8)) bus();
    assign bus.ready = ready;

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE (100_000),
        .CLK_FREQ  (1_000_000)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .rx_sig(rx_sig),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Model: frames schedule their outcome at the stop/parity sample edge; the word register follows valid/ready rules.
    always @(negedge clk) begin
        logic prev_v;
        logic hs;
        logic e_ferr;
        logic e_ovr;
        logic e_perr;
        ev_t  ev;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        e_perr = 1'b0;
        if (!rstn_q) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            evq.delete();
        end else begin
            prev_v    = exp_valid;
            hs        = prev_v && ready_q;
            exp_valid = prev_v && !hs;
            while (evq.size() > 0 && evq[0].e <= edge_n) begin
                ev = evq.pop_front();
                if (ev.kind == EV_WORD) begin
                    if (!prev_v || hs) begin
                        exp_valid = 1'b1;
                        exp_data  = ev.d;
                    end else begin
                        e_ovr = 1'b1;
                    end
                end else if (ev.kind == EV_FERR) begin
                    e_ferr = 1'b1;
                end else begin
                    e_perr = 1'b1;
                end
            end
        end
        check("valid", bus.valid, exp_valid);
        check("data", bus.data, exp_data);
        check("frame_err", bus.frame_err, e_ferr);
        check("overrun", bus.overrun, e_ovr);
`ifdef UART_RX_PARITY_EN
        check("parity_err", bus.parity_err, e_perr);
        n_perr += bus.parity_err;
`endif
        if (bus.valid && !valid_q) begin
            n_vrise++;
            last_vrise = edge_n;
        end
        valid_q = bus.valid;
        n_ferr += bus.frame_err;
        n_ovr  += bus.overrun;
        ready_q = ready;
        rstn_q  = rstn;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok, output int first);
        ev_t ev;
        first = edge_n + 1;
        if (PAR_EN != 0 && !par_ok) begin
            ev.e    = first + 2 + H + 9 * P;
            ev.kind = EV_PERR;
            ev.d    = d;
            evq.push_back(ev);
        end
        ev.e    = first + 2 + H + (9 + PAR_EN) * P;
        ev.kind = stop_b ? EV_WORD : EV_FERR;
        ev.d    = d;
        evq.push_back(ev);
        rx_sig = 1'b0;
        tick(P);
        for (int i = 0; i < 8; i++) begin
            rx_sig = d[i];
            tick(P);
        end
        if (PAR_EN != 0) begin
            rx_sig = par_ok ? ^d : ~^d;
            tick(P);
        end
        rx_sig = stop_b;
        tick(P);
    endtask

    initial begin
        int f;
        int vr0;
        int fe0;
        int ov0;
        int pe0;

        rstn   = 1'b0;
        ready  = 1'b1;
        rx_sig = 1'b1;
        tick(4);
        check("reset_valid", bus.valid, 0);
        check("reset_data", bus.data, 0);
        rstn = 1'b1;
        tick(20);

        vr0 = n_vrise; fe0 = n_ferr; ov0 = n_ovr;
        send_frame(8'hA5, 1'b1, 1'b1, f);
        tick(20);
        check("a5_words", n_vrise - vr0, 1);
        check("a5_latency", last_vrise - f, 97 + 10 * PAR_EN);
        check("a5_data", bus.data, 8'hA5);
        check("a5_valid_dropped", bus.valid, 0);
        check("a5_ferr", n_ferr - fe0, 0);
        check("a5_ovr", n_ovr - ov0, 0);

        ready = 1'b0;
        vr0 = n_vrise; ov0 = n_ovr;
        send_frame(8'h3C, 1'b1, 1'b1, f);
        send_frame(8'hC3, 1'b1, 1'b1, f);
        tick(20);
        check("ovr_valid_held", bus.valid, 1);
        check("ovr_data", bus.data, 8'h3C);
        check("ovr_pulses", n_ovr - ov0, 1);
        check("ovr_words", n_vrise - vr0, 1);
        ready = 1'b1;
        tick(3);
        check("ovr_drained", bus.valid, 0);
        check("ovr_data_kept", bus.data, 8'h3C);

        vr0 = n_vrise;
        rx_sig = 1'b0;
        tick(3);
        rx_sig = 1'b1;
        tick(40);
        check("glitch_no_word", n_vrise - vr0, 0);

        vr0 = n_vrise; fe0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b1, f);
        tick(30);
        rx_sig = 1'b1;
        tick(20);
        send_frame(8'h0F, 1'b1, 1'b1, f);
        tick(20);
        check("ferr_pulses", n_ferr - fe0, 1);
        check("ferr_words", n_vrise - vr0, 1);
        check("ferr_next_data", bus.data, 8'h0F);

        vr0 = n_vrise;
        rx_sig = 1'b0;
        tick(P);
        rx_sig = 1'b1;
        tick(4 * P + 5);
        rstn = 1'b0;
        tick(3);
        check("midreset_valid", bus.valid, 0);
        check("midreset_data", bus.data, 0);
        rstn = 1'b1;
        tick(30);
        send_frame(8'h81, 1'b1, 1'b1, f);
        tick(20);
        check("midreset_words", n_vrise - vr0, 1);
        check("midreset_data_81", bus.data, 8'h81);

`ifdef UART_RX_PARITY_EN
        pe0 = n_perr; vr0 = n_vrise;
        send_frame(8'h07, 1'b1, 1'b0, f);
        tick(20);
        check("par_bad_pulse", n_perr - pe0, 1);
        check("par_bad_word", n_vrise - vr0, 1);
        check("par_bad_data", bus.data, 8'h07);
        pe0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1, f);
        tick(20);
        check("par_good_pulse", n_perr - pe0, 0);
`else
        pe0 = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
